ftdi_fb_loader: RTL and testbench
=================================

# ftdi_fb_loader

Parametrised FT232H synchronous-FIFO receiver that streams host bytes into the framebuffer. It runs the OE/RD read handshake on the FTDI clock and packs little-endian bytes into pixel words. It writes those words to sequential framebuffer addresses and handles end-of-frame sync words. Buffer swaps are deferred to the display frame boundary. It sits between the FTDI pins and the double-buffered framebuffer write port, and replaces the earlier read-only stub.

## Interface
Parameters:
- DATA_W, 20, framebuffer word width (pixel bits).
- ADDR_W, 14, framebuffer address width.
- FB_WORDS, 16384, words per buffer; legal range 1..2**ADDR_W.
- BYTES_PER_WORD, 3, bytes per packed word; BYTES_PER_WORD*8 must be > DATA_W.

Ports:
- clk_60  in  1  FTDI 60 MHz clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- data_in  in  8  FTDI data bus.
- rxf_n  in  1  low = FIFO has data.
- txe_n  in  1  unused; no writes to host.
- rd_n  out  1  read strobe, active low.
- wr_n  out  1  tied 1.
- oe_n  out  1  bus output-enable to FTDI, active low.
- fb_wdata  out  DATA_W  write data.
- fb_waddr  out  ADDR_W  write address.
- fb_we  out  1  write strobe, one cycle per word.
- frame_start  in  1  one-cycle pulse at the display frame boundary, synchronous to clk_60.
- fb_sel  out  1  buffer currently being written; the display reads !fb_sel.
- overflow  out  1  sticky; set when pixel words exceed FB_WORDS in one frame.

## Operation
- Bus FSM states:
  - IDLE: oe_n=1, rd_n=1.
  - TURN: oe_n=0, rd_n=1.
  - READ: oe_n=0.
- Bus FSM transitions:
  - IDLE→TURN when rxf_n=0.
  - TURN→READ when rxf_n=0; TURN→IDLE otherwise.
  - READ→IDLE when rxf_n=1.
- rd_n = !(state==READ) | rxf_n, combinational.
- A byte is accepted on a clk_60 edge where rd_n=0 and rxf_n=0.
- Packing: byte counter bcnt runs 0..BYTES_PER_WORD-1 and increments per accepted byte. Byte n goes to bits [8n+7:8n] of the word register.
- On the last byte the word is complete and bcnt returns to 0.
- Sync flag: bit BYTES_PER_WORD*8-1 of the completed word.
- Pixel word (flag=0):
  - If addr < FB_WORDS: write word[DATA_W-1:0] at addr, then addr+1.
  - Otherwise: no write; overflow is set.
- Sync word (flag=1):
  - No write; addr←0; swap_pending←1.
- Swap: on frame_start while swap_pending=1, fb_sel toggles and swap_pending clears.
- frame_start without a pending swap: no effect.
- A second sync word before the swap only re-zeros addr; it does not cause a double toggle.
- overflow clears only on reset.
- Reset (any cycle, including mid-word or in READ): state=IDLE, bcnt=0, addr=0, swap_pending=0, fb_sel=0, overflow=0, fb_we=0, fb_wdata=0, fb_waddr=0, oe_n=1, rd_n=1, wr_n=1.
- A partial word in progress at reset is discarded.

## Timing
- The first byte can be accepted 2 edges after rxf_n falls in IDLE: IDLE→TURN, then TURN→READ.
- In READ, throughput is 1 byte per cycle.
- Write latency: last byte accepted at edge k → fb_we=1 with fb_wdata/fb_waddr valid during cycle k+1, for exactly one cycle.
- Sync-word effects are visible in cycle k+1: addr reads 0, swap_pending=1.
- Swap latency: frame_start sampled at edge j → fb_sel toggles after edge j.
- Simultaneous events:
  - A sync word completing on the same edge as frame_start: the swap is not taken that frame; it waits for the next frame_start.
  - A pixel write in cycle k+1 is unaffected by a swap on edge k+1; the write goes to the old fb_sel buffer.
- rxf_n rising mid-word: bcnt is held and the word resumes on the next READ entry.
- Every READ entry passes through TURN, including re-entry.

## Structure
- Shared package ftdi_pkg: FSM state enum (IDLE/TURN/READ) and the SYNC flag-position function of BYTES_PER_WORD.
- One natural sub-module, ftdi_sync_fifo_if: the bus FSM plus rd_n/oe_n. It outputs byte_valid/byte_data to the packer.
- Packing, address counter and swap logic live in the top module.

## Test plan
- Reset, then rxf_n=0 with bytes 0x34,0x12,0x05: oe_n low 1 cycle before rd_n; one write, fb_waddr=0, fb_wdata=20'h51234.
- 3 pixel words, then sync word 0x00,0x00,0x80, then frame_start: addrs 0,1,2 written; no write for the sync word; fb_sel 0→1 after frame_start; next pixel goes to addr 0.
- rxf_n high after byte 2 of a word for 5 cycles, then low: state goes IDLE→TURN→READ; the word completes with correct data and a single fb_we.
- FB_WORDS=4, 6 pixel words: writes at addrs 0..3 only; overflow=1 after word 5; a sync word resets addr but overflow stays 1.
- Two sync words, then 2 frame_start pulses: exactly one fb_sel toggle. Sync completing on the same edge as frame_start: the toggle occurs on the next frame_start.
- rst_n=0 mid-word in READ: all outputs at reset values next cycle; a fresh 3-byte word after release writes addr 0 with only the new bytes.

Source files
------------

// File: rtl/ftdi_pkg.sv
// ftdi_pkg: shared types for the FTDI framebuffer loader.
// Bus FSM state encoding and the sync-flag bit position helper.
package ftdi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        READ
    } bus_state_e;

    // The sync flag is the top bit of a packed word.
    function automatic int sync_bit(input int bytes_per_word);
        return bytes_per_word * 8 - 1;
    endfunction

endpackage

// File: rtl/ftdi_fb_loader_if.sv
// ftdi_fb_loader_if: FT232H synchronous-FIFO pin bundle.
// master = FTDI chip side, slave = loader side.
interface ftdi_fb_loader_if;

    logic [7:0] data_in;
    logic       rxf_n;
    logic       txe_n;
    logic       rd_n;
    logic       wr_n;
    logic       oe_n;

    modport master (
        output data_in,
        output rxf_n,
        output txe_n,
        input  rd_n,
        input  wr_n,
        input  oe_n
    );

    modport slave (
        input  data_in,
        input  rxf_n,
        input  txe_n,
        output rd_n,
        output wr_n,
        output oe_n
    );

endinterface

// File: rtl/ftdi_sync_fifo_if.sv
// ftdi_sync_fifo_if: OE/RD read handshake FSM for the FT232H.
// Emits one byte_valid pulse per byte taken from the FIFO.
module ftdi_sync_fifo_if
    import ftdi_pkg::*;
(
    input  logic       clk_60,
    input  logic       rst_n,
    input  logic       rxf_n,
    input  logic [7:0] data_in,
    output logic       rd_n,
    output logic       oe_n,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    bus_state_e state_q;
    bus_state_e state_d;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_60) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every READ entry goes through a TURN cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!rxf_n) state_d = TURN;
            TURN:    state_d = rxf_n ? IDLE : READ;
            READ:    if (rxf_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign oe_n       = (state_q == IDLE);
    assign rd_n       = (state_q != READ) | rxf_n;
    assign byte_valid = !rd_n && !rxf_n;
    assign byte_data  = data_in;

endmodule

// File: rtl/ftdi_fb_loader.sv
// ftdi_fb_loader: packs FTDI bytes into pixel words and writes them
// to sequential framebuffer addresses with deferred buffer swaps.
module ftdi_fb_loader
    import ftdi_pkg::*;
#(
    parameter int DATA_W         = 20,
    parameter int ADDR_W         = 14,
    parameter int FB_WORDS       = 16384,
    parameter int BYTES_PER_WORD = 3
) (
    input  logic              clk_60,
    input  logic              rst_n,
    ftdi_fb_loader_if.slave   bus,
    output logic [DATA_W-1:0] fb_wdata,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic              fb_we,
    input  logic              frame_start,
    output logic              fb_sel,
    output logic              overflow
);

    localparam int WORD_W   = BYTES_PER_WORD * 8;
    localparam int SYNC_POS = sync_bit(BYTES_PER_WORD);
    localparam int BCNT_W   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(FB_WORDS);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       unused_txe;

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              pend_q, pend_d;
    logic              sel_q, sel_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              sync_done;

    assign unused_txe = bus.txe_n;
    assign bus.wr_n   = 1'b1;

    ftdi_sync_fifo_if u_bus (
        .clk_60     (clk_60),
        .rst_n      (rst_n),
        .rxf_n      (bus.rxf_n),
        .data_in    (bus.data_in),
        .rd_n       (bus.rd_n),
        .oe_n       (bus.oe_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    // Packer, address counter and swap bookkeeping registers.
    always_ff @(posedge clk_60) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            sel_q   <= 1'b0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
        end else begin
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
        end
    end

    // Byte insertion, word dispatch and deferred buffer swap.
    always_comb begin
        bcnt_d    = bcnt_q;
        word_d    = word_q;
        addr_d    = addr_q;
        pend_d    = pend_q;
        sel_d     = sel_q;
        ovf_d     = ovf_q;
        we_d      = 1'b0;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        sync_done = 1'b0;
        if (byte_valid) begin
            for (int n = 0; n < BYTES_PER_WORD; n++) begin
                if (bcnt_q == BCNT_W'(n)) word_d[n*8 +: 8] = byte_data;
            end
            if (bcnt_q == BCNT_LAST) begin
                bcnt_d = '0;
                if (word_d[SYNC_POS]) begin
                    addr_d    = '0;
                    pend_d    = 1'b1;
                    sync_done = 1'b1;
                end else if (addr_q < ADDR_LIM) begin
                    we_d    = 1'b1;
                    wdata_d = word_d[DATA_W-1:0];
                    waddr_d = addr_q[ADDR_W-1:0];
                    addr_d  = addr_q + (ADDR_W + 1)'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                bcnt_d = bcnt_q + BCNT_W'(1);
            end
        end
        // A sync landing on the frame edge waits for the next frame.
        if (frame_start && pend_q && !sync_done) begin
            sel_d  = ~sel_q;
            pend_d = 1'b0;
        end
    end

    assign fb_we    = we_q;
    assign fb_wdata = wdata_q;
    assign fb_waddr = waddr_q;
    assign fb_sel   = sel_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ftdi_fb_loader.sv
// tb_ftdi_fb_loader: directed bench with a write scoreboard.
// Instance A uses default sizing, instance B uses FB_WORDS=4.
module tb_ftdi_fb_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_v = 8'h00;
    logic       rxf_v = 1'b1;
    logic       frame_v = 1'b0;

    logic [19:0] wdata_a, wdata_b;
    logic [13:0] waddr_a, waddr_b;
    logic        we_a, we_b, sel_a, sel_b, ovf_a, ovf_b;

    int checks = 0;
    int failures = 0;

    logic [34:0] q_a[$];
    logic [34:0] q_b[$];
    int m_addr[2];
    int m_fbw[2];
    logic m_sel, m_pend;

    ftdi_fb_loader_if bus_a ();
    ftdi_fb_loader_if bus_b ();

    assign bus_a.data_in = data_v;
    assign bus_a.rxf_n   = rxf_v;
    assign bus_a.txe_n   = 1'b1;
    assign bus_b.data_in = data_v;
    assign bus_b.rxf_n   = rxf_v;
    assign bus_b.txe_n   = 1'b1;

    ftdi_fb_loader u_a (
        .clk_60      (clk),
        .rst_n       (rst_n),
        .bus         (bus_a.slave),
        .fb_wdata    (wdata_a),
        .fb_waddr    (waddr_a),
        .fb_we       (we_a),
        .frame_start (frame_v),
        .fb_sel      (sel_a),
        .overflow    (ovf_a)
    );

    ftdi_fb_loader #(.FB_WORDS(4)) u_b (
        .clk_60      (clk),
        .rst_n       (rst_n),
        .bus         (bus_b.slave),
        .fb_wdata    (wdata_b),
        .fb_waddr    (waddr_b),
        .fb_we       (we_b),
        .frame_start (frame_v),
        .fb_sel      (sel_b),
        .overflow    (ovf_b)
    );

    always #8 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every fb_we must match the oldest expected write.
    always @(negedge clk) begin
        if (we_a) begin
            if (q_a.size() == 0) check("unexpected_write_a", 1, 0);
            else check("write_a", {29'd0, sel_a, waddr_a, wdata_a}, {29'd0, q_a.pop_front()});
        end
        if (we_b) begin
            if (q_b.size() == 0) check("unexpected_write_b", 1, 0);
            else check("write_b", {29'd0, sel_b, waddr_b, wdata_b}, {29'd0, q_b.pop_front()});
        end
    end

    task automatic model_reset();
        m_addr[0] = 0;
        m_addr[1] = 0;
        m_sel     = 1'b0;
        m_pend    = 1'b0;
    endtask

    task automatic model_word(input logic [7:0] b0, b1, b2);
        logic [23:0] w;
        w = {b2, b1, b0};
        if (w[23]) begin
            m_addr[0] = 0;
            m_addr[1] = 0;
            m_pend    = 1'b1;
        end else begin
            if (m_addr[0] < m_fbw[0]) begin
                q_a.push_back({m_sel, 14'(m_addr[0]), w[19:0]});
                m_addr[0]++;
            end
            if (m_addr[1] < m_fbw[1]) begin
                q_b.push_back({m_sel, 14'(m_addr[1]), w[19:0]});
                m_addr[1]++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fs);
        bit ok;
        ok = 0;
        data_v = b;
        rxf_v = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (bus_a.rd_n === 1'b0) ok = 1;
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            return;
        end
        frame_v = fs;
        @(posedge clk);
        #1;
        frame_v = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b0, b1, b2);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        model_word(b0, b1, b2);
    endtask

    task automatic idle(input int n);
        rxf_v = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_frame();
        frame_v = 1'b1;
        @(posedge clk);
        #1;
        frame_v = 1'b0;
        if (m_pend) begin
            m_sel  = ~m_sel;
            m_pend = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rxf_v = 1'b1;
        frame_v = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        m_fbw[0] = 16384;
        m_fbw[1] = 4;
        model_reset();

        // Reset state
        do_reset();
        check("rst_oe_n", bus_a.oe_n, 1);
        check("rst_rd_n", bus_a.rd_n, 1);
        check("rst_wr_n", bus_a.wr_n, 1);
        check("rst_we", we_a, 0);
        check("rst_sel", sel_a, 0);
        check("rst_ovf", {ovf_a, ovf_b}, 0);
        check("rst_wdata", wdata_a, 0);
        check("rst_waddr", waddr_a, 0);

        // First word: TURN precedes READ, then one write
        data_v = 8'h34;
        rxf_v = 1'b0;
        @(posedge clk);
        #1;
        check("turn_oe_n", bus_a.oe_n, 0);
        check("turn_rd_n", bus_a.rd_n, 1);
        @(posedge clk);
        #1;
        check("read_rd_n", bus_a.rd_n, 0);
        send_word(8'h34, 8'h12, 8'h05);
        check("first_we", we_a, 1);
        check("first_wdata", wdata_a, 20'h51234);
        check("first_waddr", waddr_a, 0);
        idle(1);
        check("first_we_drop", we_a, 0);
        idle(2);

        // Three pixels, sync, frame swap, next pixel at addr 0
        do_reset();
        send_word(8'h01, 8'h02, 8'h03);
        send_word(8'h11, 8'h12, 8'h13);
        send_word(8'h21, 8'h22, 8'h03);
        send_word(8'h00, 8'h00, 8'h80);
        idle(3);
        check("sel_before_swap", sel_a, 0);
        pulse_frame();
        check("sel_after_swap", sel_a, 1);
        send_word(8'hAB, 8'hCD, 8'h0E);
        idle(3);

        // rxf_n stall mid-word
        do_reset();
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b0);
        rxf_v = 1'b1;
        @(posedge clk);
        #1;
        check("stall_idle_oe_n", bus_a.oe_n, 1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        data_v = 8'h07;
        rxf_v = 1'b0;
        @(posedge clk);
        #1;
        check("resume_turn", {bus_a.oe_n, bus_a.rd_n}, 2'b01);
        @(posedge clk);
        #1;
        check("resume_read", {bus_a.oe_n, bus_a.rd_n}, 2'b00);
        send_byte(8'h07, 1'b0);
        model_word(8'h5A, 8'hA5, 8'h07);
        check("resume_we", we_a, 1);
        idle(3);

        // Overflow on the FB_WORDS=4 instance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_word(8'(8'h40 + i), 8'(8'h60 + i), 8'(i));
            if (i == 3) check("ovf_after_4", ovf_b, 0);
            if (i == 4) check("ovf_after_5", ovf_b, 1);
        end
        send_word(8'h00, 8'h00, 8'h80);
        idle(2);
        check("ovf_sticky", ovf_b, 1);
        check("ovf_a_clear", ovf_a, 0);
        pulse_frame();
        check("ovf_sel", sel_b, 1);
        send_word(8'h99, 8'h88, 8'h07);
        send_word(8'h77, 8'h66, 8'h05);

        // Reset in READ mid-word
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        data_v = 8'hCC;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_pins", {bus_a.oe_n, bus_a.rd_n, bus_a.wr_n}, 3'b111);
        check("midrst_we", we_a, 0);
        check("midrst_sel", sel_a, 0);
        check("midrst_ovf", ovf_b, 0);
        check("midrst_waddr", waddr_a, 0);
        check("midrst_wdata", wdata_a, 0);
        rxf_v = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        send_word(8'h01, 8'h02, 8'h03);
        check("fresh_word", {we_a, waddr_a, wdata_a}, {1'b1, 14'd0, 20'h30201});
        idle(3);

        // Double sync gives one toggle; coincident sync defers swap
        do_reset();
        send_word(8'h00, 8'h00, 8'h80);
        send_word(8'h00, 8'h00, 8'h80);
        idle(2);
        pulse_frame();
        check("dsync_first", sel_a, 1);
        idle(1);
        pulse_frame();
        check("dsync_second", sel_a, 1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h80, 1'b1);
        model_word(8'h00, 8'h00, 8'h80);
        idle(2);
        check("coinc_no_swap", sel_a, 1);
        pulse_frame();
        check("coinc_next_swap", sel_a, 0);
        send_word(8'h11, 8'h22, 8'h03);
        idle(4);

        check("queue_a_empty", q_a.size(), 0);
        check("queue_b_empty", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
